// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl
// Multi-cycle instruction sequencer for the KGP-RISC core. Steps each
// instruction through FETCH -> DECODE -> EXEC -> WB, owns the program
// counter, drives the next-PC mux select and counts retired instructions.
//
// Ports
//   clk, rst        : clock; synchronous active-high reset
//   start           : leave IDLE and begin fetching
//   imem_req/ack    : instruction-memory fetch handshake (FETCH only)
//   halt_in         : HALT opcode, sampled in DECODE
//   stall           : hold EXEC for multi-cycle operations
//   branch_taken/
//   branch_target   : branch decision and destination, sampled in EXEC
//   pc              : registered program counter (doubles as fetch address)
//   pc_sel          : next-PC mux select, 0 = PC+1, 1 = latched target
//   ir_load, reg_we : single-cycle IR load / register-file write enables
//   state           : current FSM encoding
//   halted          : core is in the terminal HALT state
//   retired         : saturating retired-instruction count
module pc_seq_ctrl #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic              halt_in,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_sel,
  output logic              ir_load,
  output logic              reg_we,
  output logic [2:0]        state,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                br_q, br_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      br_q      <= 1'b0;
      tgt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      br_q      <= br_d;
      tgt_q     <= tgt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    br_d      = br_q;
    tgt_d     = tgt_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    reg_we    = 1'b0;
    pc_sel    = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      // Request is held for as long as memory takes; no timeout.
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = halt_in ? S_HALT : S_EXEC;
      end

      // Branch inputs are only trusted on the cycle the stall drops, so
      // values wiggling during a multi-cycle op are never latched.
      S_EXEC: begin
        if (!stall) begin
          br_d    = branch_taken;
          tgt_d   = branch_target;
          state_d = S_WB;
        end
      end

      // PC update happens at the closing WB edge so pc stays stable as the
      // fetch address for the whole following FETCH.
      S_WB: begin
        reg_we  = 1'b1;
        pc_sel  = br_q;
        pc_d    = br_q ? tgt_q : pc_q + ADDR_W'(1);
        if (retired_q != CNT_MAX) retired_d = retired_q + CNT_W'(1);
        state_d = S_FETCH;
      end

      // Terminal until reset; start is ignored.
      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc      = pc_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the KGP-RISC core. Owns the 10-bit program counter and drives the select of the 2:1 10-bit next-PC mux (in0 = PC+1, in1 = branch target). Steps each instruction through FETCH/DECODE/EXEC/WB and handshakes with instruction memory. Pulses the IR-load and register-write enables and counts retired instructions.

Parameters:
ADDR_W, 10, PC / instruction-address width (matches next-PC mux width)
RESET_PC, 10'd0, PC value after reset
CNT_W, 16, retired-instruction counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin execution from IDLE
imem_req  output  1  instruction fetch request to instruction memory
imem_ack  input  1  instruction memory has data on this cycle
halt_in  input  1  decoded HALT opcode, sampled only in DECODE
stall  input  1  hold EXEC (multi-cycle ALU/memory op)
branch_taken  input  1  branch decision from ALU/branch unit, sampled in EXEC
branch_target  input  ADDR_W  branch destination, sampled in EXEC
pc  output  ADDR_W  current program counter, registered
pc_sel  output  1  next-PC mux select: 0 = PC+1, 1 = latched target
ir_load  output  1  one-cycle instruction-register load enable
reg_we  output  1  one-cycle register-file write enable
state  output  3  current FSM state encoding
halted  output  1  core halted
retired  output  CNT_W  saturating retired-instruction count

Behaviour:
- Reset: rst is sampled at the rising edge and dominates every other input.
  - Reset values: state=IDLE, pc=RESET_PC, retired=0, branch latch=0, target latch=0.
  - Outputs while in IDLE after reset: imem_req=0, ir_load=0, reg_we=0, pc_sel=0, halted=0.
  - Reset mid-instruction abandons it: no retire, no PC update, imem_req low from the next cycle.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Codes 6 and 7 go to IDLE on the next edge.
- IDLE:
  - All enables are 0.
  - start=1 -> FETCH. Otherwise stay in IDLE.
- FETCH:
  - imem_req=1 combinationally for every cycle spent in FETCH.
  - imem_ack=1 -> ir_load=1 in that same cycle, then -> DECODE.
  - Otherwise stay in FETCH; no timeout.
- imem_ack is ignored in every state other than FETCH.
- DECODE: lasts one cycle.
  - halt_in=1 -> HALT.
  - Otherwise -> EXEC.
- EXEC:
  - stall=1 -> stay in EXEC; branch inputs are not sampled.
  - stall=0 -> capture br_q <= branch_taken and tgt_q <= branch_target, then -> WB.
  - Only the values present on the cycle stall is low are used.
- WB: lasts one cycle.
  - reg_we=1.
  - pc_sel=br_q (pc_sel is 0 in all other states).
  - At the closing edge: pc <= pc_sel ? tgt_q : pc+1, retired increments, state -> FETCH.
- HALT:
  - halted=1 and all enables are 0.
  - Terminal until rst; start is ignored.
  - The halting instruction does not retire and pc is unchanged.
- Arithmetic:
  - pc+1 is modulo 2^ADDR_W, so 1023 -> 0.
  - retired saturates at 2^CNT_W-1 and does not wrap.
- Latency: with no stall and an immediate ack, each instruction takes 4 cycles (FETCH, DECODE, EXEC, WB).
- Timing of pc: pc is stable from the WB closing edge through the whole next FETCH, so it can be used directly as the instruction-memory address.
- start asserted in any state other than IDLE has no effect.

Test Plan:
1. Sequential step: rst 2 cycles, start pulse, imem_ack=1 in first FETCH cycle, branch_taken=0 -> state 1,2,3,4,1. ir_load high in the FETCH cycle. reg_we high in WB with pc_sel=0. pc 0->1 at the WB edge. retired=1.
2. Taken branch: branch_taken=1, branch_target=10'd17 in EXEC -> pc_sel=1 in WB, pc=17 after WB. Next instruction sequential, no branch -> pc=18, pc_sel=0.
3. Delayed fetch: imem_ack arrives on the 4th FETCH cycle -> imem_req high exactly 4 cycles, ir_load a single pulse on the 4th, pc held at its value.
4. Stall with changing inputs: stall=1 for 2 EXEC cycles with branch_taken=1/target=5, released with branch_taken=0 -> no branch, pc=pc+1, EXEC lasted 3 cycles.
5. Wrap-around: branch to 10'd1023, next instruction sequential -> pc=0. Preload retired near max (CNT_W=4 build) -> stays at 15.
6. Halt and reset:
   - halt_in=1 in DECODE -> state=5, halted=1, retired and pc unchanged, start pulses ignored for 10 cycles.
   - rst=1 asserted mid-FETCH -> next edge state=0, pc=0, imem_req=0, halted=0.
